// File: rtl/ysyx_24090003_ifu.sv
// Instruction fetch unit: one outstanding imem request, redirect with kill of
// an in-flight response, and halt on a misaligned redirect target.
module ysyx_24090003_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_misalign
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_inst;
    logic              r_inst_valid;
    logic              r_kill;
    logic              r_misalign;

    logic              w_req_fire;
    logic              w_redir_misalign;
    logic [XLEN-1:0]   w_pc_inc;

    assign o_imem_req_valid = (r_state == S_REQ) && !r_misalign;
    assign o_imem_addr      = r_pc;
    assign o_pc             = r_pc;
    assign o_inst           = r_inst;
    assign o_inst_valid     = r_inst_valid;
    assign o_misalign       = r_misalign;

    assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;
    assign w_redir_misalign = |i_redirect_pc[1:0];
    assign w_pc_inc         = r_pc + XLEN'(4);

    // Fetch FSM; a redirect always wins over the normal sequential step.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
            r_kill       <= 1'b0;
            r_misalign   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end

                S_REQ: begin
                    if (i_redirect) begin
                        r_pc       <= i_redirect_pc;
                        r_misalign <= w_redir_misalign;
                        if (w_req_fire) begin
                            r_kill  <= 1'b1;
                            r_state <= S_WAIT;
                        end
                    end else if (w_req_fire) begin
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (i_redirect) begin
                        r_pc       <= i_redirect_pc;
                        r_misalign <= w_redir_misalign;
                        if (i_imem_resp_valid) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_kill  <= 1'b1;
                        end
                    end else if (i_imem_resp_valid) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_inst       <= i_imem_resp_data;
                            r_inst_valid <= 1'b1;
                            r_state      <= S_OUT;
                        end
                    end
                end

                S_OUT: begin
                    if (i_redirect) begin
                        r_pc         <= i_redirect_pc;
                        r_misalign   <= w_redir_misalign;
                        r_inst_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end else if (i_inst_ready) begin
                        r_pc         <= w_pc_inc;
                        r_inst_valid <= 1'b0;
                        r_state      <= S_REQ;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_ifu.sv
// Self-checking bench for the IFU: behavioural imem with programmable latency,
// address/instruction scoreboards, a vector table plus redirect/reset sequences.
module tb_ysyx_24090003_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        int          lat;
        int          stall;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk;
    logic        i_rst_n;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_addr;
    logic        i_imem_resp_valid;
    logic [31:0] i_imem_resp_data;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_misalign;

    int          n_vec;
    int          n_err;
    exp_t        sb_q[$];
    logic [31:0] addr_q[$];
    logic        mem_busy;
    int          mem_cnt;
    int          mem_lat;
    logic [31:0] mem_addr;
    logic        consumed;

    ysyx_24090003_ifu #(.RESET_PC(RESET_PC)) dut (
        .i_clk             (clk),
        .i_rst_n           (i_rst_n),
        .o_imem_req_valid  (o_imem_req_valid),
        .i_imem_req_ready  (i_imem_req_ready),
        .o_imem_addr       (o_imem_addr),
        .i_imem_resp_valid (i_imem_resp_valid),
        .i_imem_resp_data  (i_imem_resp_data),
        .o_inst_valid      (o_inst_valid),
        .i_inst_ready      (i_inst_ready),
        .o_inst            (o_inst),
        .o_pc              (o_pc),
        .i_redirect        (i_redirect),
        .i_redirect_pc     (i_redirect_pc),
        .o_misalign        (o_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == RESET_PC) ? 32'h0010_0093 : (a ^ 32'h1234_0013);
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event expected none at %0t", name, $time);
    endtask

    // Drive the imem model and scoreboard for one cycle, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        if (mem_busy && mem_cnt == 1) begin
            i_imem_resp_valid = 1'b1;
            i_imem_resp_data  = mem_word(mem_addr);
            mem_busy          = 1'b0;
        end else begin
            if (mem_busy) mem_cnt--;
            i_imem_resp_valid = 1'b0;
            i_imem_resp_data  = $urandom;
        end
        if (i_rst_n && o_imem_req_valid && i_imem_req_ready) begin
            if (addr_q.size() == 0) fail("unexpected_req");
            else chk32("req_addr", o_imem_addr, addr_q.pop_front());
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = o_imem_addr;
        end
        if (i_rst_n && o_inst_valid && i_inst_ready && !i_redirect) begin
            if (sb_q.size() == 0) begin
                fail("unexpected_inst");
            end else begin
                e = sb_q.pop_front();
                chk32("out_pc", o_pc, e.pc);
                chk32("out_inst", o_inst, e.inst);
            end
            consumed = 1'b1;
        end
        @(negedge clk);
    endtask

    // One complete fetch starting in S_REQ; checks cadence and stall stability.
    task automatic fetch_one(input int lat, input int stall, input logic [31:0] pc, input logic [31:0] inst);
        int cyc;
        int left;
        mem_lat          = lat;
        i_imem_req_ready = 1'b1;
        i_inst_ready     = 1'b0;
        left             = stall;
        addr_q.push_back(pc);
        sb_q.push_back('{pc, inst});
        consumed = 1'b0;
        cyc      = 0;
        while (!consumed && cyc < 40) begin
            if (o_inst_valid && left > 0) begin
                chk32("stall_pc", o_pc, pc);
                chk32("stall_inst", o_inst, inst);
                chk1("stall_noreq", o_imem_req_valid, 1'b0);
                left--;
                i_inst_ready = 1'b0;
            end else begin
                i_inst_ready = o_inst_valid;
            end
            tick();
            cyc++;
        end
        i_inst_ready = 1'b0;
        if (!consumed) fail("fetch_timeout");
        chk32("cadence", 32'(cyc), 32'(2 + lat + stall));
    endtask

    task automatic redirect_tick(input logic [31:0] tgt);
        i_redirect    = 1'b1;
        i_redirect_pc = tgt;
        tick();
        i_redirect    = 1'b0;
    endtask

    initial begin
        vec_t vt[6];
        int   cnt;

        vt[0] = '{1, 0, 32'h8000_0000, 32'h0010_0093};
        vt[1] = '{1, 0, 32'h8000_0004, mem_word(32'h8000_0004)};
        vt[2] = '{2, 0, 32'h8000_0008, mem_word(32'h8000_0008)};
        vt[3] = '{1, 5, 32'h8000_000C, mem_word(32'h8000_000C)};
        vt[4] = '{3, 2, 32'h8000_0010, mem_word(32'h8000_0010)};
        vt[5] = '{1, 0, 32'h8000_0014, mem_word(32'h8000_0014)};

        n_vec = 0; n_err = 0;
        mem_busy = 1'b0; mem_cnt = 0; mem_lat = 1; mem_addr = '0; consumed = 1'b0;
        i_rst_n = 1'b0; i_imem_req_ready = 1'b0; i_imem_resp_valid = 1'b0;
        i_imem_resp_data = '0; i_inst_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;

        // Reset values
        @(negedge clk); @(negedge clk);
        chk1("rst_req_valid", o_imem_req_valid, 1'b0);
        chk1("rst_inst_valid", o_inst_valid, 1'b0);
        chk32("rst_inst", o_inst, 32'h0);
        chk32("rst_pc", o_pc, RESET_PC);
        chk32("rst_addr", o_imem_addr, RESET_PC);
        chk1("rst_misalign", o_misalign, 1'b0);
        i_rst_n = 1'b1;
        chk1("idle_no_req", o_imem_req_valid, 1'b0);
        tick();
        chk1("req_after_idle", o_imem_req_valid, 1'b1);

        // Sequential fetches: latency / decode-stall table
        for (int i = 0; i < 6; i++) fetch_one(vt[i].lat, vt[i].stall, vt[i].pc, vt[i].inst);

        // Redirect in S_WAIT, response two cycles later is dropped
        mem_lat = 3; i_imem_req_ready = 1'b1; i_inst_ready = 1'b1;
        addr_q.push_back(32'h8000_0018);
        tick();
        redirect_tick(32'h8000_0100);
        cnt = 0;
        while (!o_imem_req_valid && cnt < 10) begin
            chk1("kill_no_valid", o_inst_valid, 1'b0);
            tick();
            cnt++;
        end
        chk32("kill_drop_cycles", 32'(cnt), 32'd2);
        chk32("kill_next_addr", o_imem_addr, 32'h8000_0100);
        i_inst_ready = 1'b0;
        fetch_one(1, 0, 32'h8000_0100, mem_word(32'h8000_0100));

        // Redirect together with inst_ready in S_OUT
        mem_lat = 1; i_imem_req_ready = 1'b1; i_inst_ready = 1'b0;
        addr_q.push_back(32'h8000_0104);
        tick(); tick();
        chk1("out_valid", o_inst_valid, 1'b1);
        chk32("out_hold_pc", o_pc, 32'h8000_0104);
        chk32("out_hold_inst", o_inst, mem_word(32'h8000_0104));
        i_inst_ready = 1'b1;
        redirect_tick(32'h8000_0300);
        i_inst_ready = 1'b0;
        chk1("redir_out_clr_valid", o_inst_valid, 1'b0);
        chk1("redir_out_req", o_imem_req_valid, 1'b1);
        chk32("redir_out_addr", o_imem_addr, 32'h8000_0300);
        fetch_one(1, 0, 32'h8000_0300, mem_word(32'h8000_0300));

        // Redirect in S_REQ on the same edge the request is accepted
        mem_lat = 1; i_imem_req_ready = 1'b1; i_inst_ready = 1'b1;
        addr_q.push_back(32'h8000_0304);
        redirect_tick(32'h8000_0400);
        tick();
        chk1("acc_redir_no_valid", o_inst_valid, 1'b0);
        chk1("acc_redir_req", o_imem_req_valid, 1'b1);
        chk32("acc_redir_addr", o_imem_addr, 32'h8000_0400);
        fetch_one(1, 0, 32'h8000_0400, mem_word(32'h8000_0400));

        // Redirect in S_REQ while memory is not ready
        i_imem_req_ready = 1'b0;
        redirect_tick(32'h8000_0500);
        chk32("req_redir_addr", o_imem_addr, 32'h8000_0500);
        fetch_one(1, 0, 32'h8000_0500, mem_word(32'h8000_0500));

        // Redirect in S_WAIT coinciding with the response
        mem_lat = 1; i_imem_req_ready = 1'b1; i_inst_ready = 1'b1;
        addr_q.push_back(32'h8000_0504);
        tick();
        redirect_tick(32'h8000_0600);
        chk1("wait_redir_no_valid", o_inst_valid, 1'b0);
        chk1("wait_redir_req", o_imem_req_valid, 1'b1);
        chk32("wait_redir_addr", o_imem_addr, 32'h8000_0600);
        fetch_one(1, 0, 32'h8000_0600, mem_word(32'h8000_0600));

        // Misaligned redirect halts fetch until an aligned redirect
        i_imem_req_ready = 1'b0;
        redirect_tick(32'h8000_0102);
        chk1("misalign_set", o_misalign, 1'b1);
        chk1("misalign_no_req", o_imem_req_valid, 1'b0);
        i_imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("misalign_halt", o_imem_req_valid, 1'b0);
        end
        redirect_tick(32'h8000_0200);
        chk1("misalign_clr", o_misalign, 1'b0);
        chk1("misalign_resume", o_imem_req_valid, 1'b1);
        fetch_one(1, 0, 32'h8000_0200, mem_word(32'h8000_0200));

        // PC wraps from the top of the address space
        i_imem_req_ready = 1'b0;
        redirect_tick(32'hFFFF_FFFC);
        fetch_one(1, 0, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
        chk32("wrap_addr", o_imem_addr, 32'h0000_0000);
        fetch_one(1, 0, 32'h0000_0000, mem_word(32'h0000_0000));

        // Reset during S_WAIT; stale response and idle redirect ignored
        mem_lat = 3; i_imem_req_ready = 1'b1; i_inst_ready = 1'b1;
        addr_q.push_back(32'h0000_0004);
        tick();
        #1 i_rst_n = 1'b0;
        #1;
        chk1("mid_rst_req_valid", o_imem_req_valid, 1'b0);
        chk1("mid_rst_inst_valid", o_inst_valid, 1'b0);
        chk32("mid_rst_inst", o_inst, 32'h0);
        chk32("mid_rst_pc", o_pc, RESET_PC);
        chk1("mid_rst_misalign", o_misalign, 1'b0);
        i_imem_req_ready = 1'b0;
        tick();
        i_rst_n = 1'b1;
        chk1("post_rst_idle", o_imem_req_valid, 1'b0);
        redirect_tick(32'h8000_0700);
        chk32("idle_redir_ignored", o_imem_addr, RESET_PC);
        tick();
        chk1("stale_resp_ignored", o_inst_valid, 1'b0);
        chk1("post_rst_req", o_imem_req_valid, 1'b1);
        chk32("post_rst_addr", o_imem_addr, RESET_PC);
        fetch_one(1, 0, RESET_PC, 32'h0010_0093);

        chk32("sb_drained", 32'(sb_q.size()), 32'd0);
        chk32("addr_q_drained", 32'(addr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_24090003_ifu.md
YSYX_24090003_IFU -- requirements
Module: ysyx_24090003_IFU

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the PC loaded on reset.
REQ-002 i_clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 i_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 o_imem_req_valid  out  1  SHALL indicate a fetch request to instruction memory.
REQ-005 i_imem_req_ready  in  1  SHALL indicate that memory accepts the request this cycle.
REQ-006 o_imem_addr  out  32  SHALL carry the fetch address, equal to the current PC.
REQ-007 i_imem_resp_valid  in  1  SHALL indicate that response data is valid.
REQ-008 i_imem_resp_data  in  32  SHALL carry the fetched instruction word.
REQ-009 o_inst_valid  out  1  SHALL indicate that o_inst and o_pc are valid for the decode stage.
REQ-010 i_inst_ready  in  1  SHALL indicate that the decode/execute side consumes o_inst this cycle.
REQ-011 o_inst  out  32  SHALL carry the instruction word driven to the decoder.
REQ-012 o_pc  out  32  SHALL carry the PC of o_inst.
REQ-013 i_redirect  in  1  SHALL indicate a jump or taken branch from the execute stage.
REQ-014 i_redirect_pc  in  32  SHALL carry the redirect target.
REQ-015 o_misalign  out  1  SHALL indicate that the PC is not word-aligned and that fetch is halted.

Function
REQ-016 The FSM SHALL have exactly these states: S_IDLE, S_REQ, S_WAIT, S_OUT.
REQ-017 S_IDLE SHALL go to S_REQ unconditionally one cycle after reset release.
REQ-018 o_imem_req_valid SHALL equal (state==S_REQ && !o_misalign); o_imem_addr SHALL equal the PC register.
REQ-019 In S_REQ, req_valid && req_ready SHALL move the FSM to S_WAIT; at most one request SHALL be outstanding.
REQ-020 In S_WAIT, a resp_valid without a pending kill SHALL, at that edge, latch resp_data into o_inst, set o_inst_valid=1 and move the FSM to S_OUT.
REQ-021 i_imem_resp_valid outside S_WAIT SHALL be ignored.
REQ-022 In S_OUT, o_inst, o_pc and o_inst_valid SHALL hold stable until i_inst_ready=1.
REQ-023 When i_inst_ready=1 in S_OUT, the block SHALL set pc<=pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0), clear o_inst_valid and go to S_REQ.
REQ-024 Redirect in S_REQ, request not accepted: pc<=i_redirect_pc; FSM stays in S_REQ.
REQ-025 Redirect in S_REQ with the request accepted the same cycle: pc<=i_redirect_pc; kill<=1; FSM goes to S_WAIT.
REQ-026 Redirect in S_WAIT: pc<=i_redirect_pc; kill<=1. If resp_valid arrives the same cycle, that response SHALL be dropped and the FSM SHALL go to S_REQ.
REQ-027 A response received in S_WAIT with kill=1 SHALL be dropped; the block SHALL then clear kill and go to S_REQ, and o_inst_valid SHALL stay 0.
REQ-028 Redirect in S_OUT SHALL take priority over i_inst_ready: pc<=i_redirect_pc; o_inst_valid<=0; FSM goes to S_REQ.
REQ-029 If an accepted redirect has i_redirect_pc[1:0]!=0, o_misalign SHALL be set at that edge, and it SHALL remain set until an aligned redirect clears it.
REQ-030 Redirect in S_IDLE SHALL be ignored.
REQ-031 With zero-wait memory (ready=1, response one cycle after accept), throughput SHALL be one instruction per 3 cycles.
REQ-032 o_pc SHALL equal the PC register, which holds the address of o_inst while in S_OUT.

Reset
REQ-033 While i_rst_n=0 the block SHALL hold: state=S_IDLE, pc=RESET_PC, o_inst=32'h0, o_inst_valid=0, kill=0, o_misalign=0, and therefore o_imem_req_valid=0.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding request; responses arriving before the next S_WAIT SHALL be ignored.

Verification
REQ-035 Release reset, ready=1, respond with 32'h00100093 one cycle after accept, inst_ready=1 -> addr 32'h8000_0000; o_inst=32'h00100093 with o_pc=32'h8000_0000; next addr 32'h8000_0004; 3-cycle cadence.
REQ-036 Hold inst_ready=0 for 5 cycles in S_OUT -> o_inst/o_pc stable; no new request until ready=1.
REQ-037 Redirect to 32'h8000_0100 in S_WAIT, response arrives 2 cycles later -> response dropped; next request addr 32'h8000_0100; o_inst_valid never pulses for the dropped word.
REQ-038 Redirect and inst_ready together in S_OUT -> next addr is the redirect target, not pc+4.
REQ-039 Redirect to 32'h8000_0102 -> o_misalign=1, req_valid=0; a later redirect to 32'h8000_0200 -> o_misalign=0, fetch resumes at 32'h8000_0200.
REQ-040 Assert i_rst_n=0 in S_WAIT, then release -> all outputs at their reset values; the first fetch after release is at RESET_PC.
